// File: rtl/seq_divider_if.sv
// Handshake/data bundle between a requester and the sequential divider.
// Latency: none, wires only.
// Backpressure: start is dropped by the divider while busy; nothing is queued.
// Ports: start/data_in (requester -> divider); busy/done/div_by_zero/quotient/remainder (divider -> requester).
interface seq_divider_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] data_in;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;

    modport master (
        output start,
        output data_in,
        input  busy,
        input  done,
        input  div_by_zero,
        input  quotient,
        input  remainder
    );

    modport slave (
        input  start,
        input  data_in,
        output busy,
        output done,
        output div_by_zero,
        output quotient,
        output remainder
    );
endinterface

// File: rtl/seq_divider.sv
// Unsigned divider using repeated subtraction: a remainder/divisor/quotient datapath driven by a small FSM.
// Latency: done is registered high after edge floor(N/D)+2, or after edge 2 when D is 0.
// Backpressure: start is sampled only in IDLE; while busy (including the DONE cycle) it is ignored.
// Ports: clk, rst_n (async active-low); bus.slave carries start, data_in (dividend, then divisor
//        on the next cycle), busy, done, div_by_zero, quotient, remainder.
module seq_divider #(
    parameter int WIDTH = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    seq_divider_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LDB  = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] div_q;
    logic [WIDTH-1:0] quo_q;
    logic             busy_q;
    logic             done_q;
    logic             dbz_q;

    // The comparator guards the subtractor, so R-D never wraps.
    logic             rem_ge_div;
    logic             div_is_zero;
    logic [WIDTH-1:0] rem_minus_div;

    assign rem_ge_div    = (rem_q >= div_q);
    assign div_is_zero   = (div_q == '0);
    assign rem_minus_div = rem_q - div_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            rem_q  <= '0;
            div_q  <= '0;
            quo_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        rem_q  <= bus.data_in;
                        quo_q  <= '0;
                        dbz_q  <= 1'b0;
                        busy_q <= 1'b1;
                        state  <= LDB;
                    end
                end
                LDB: begin
                    div_q <= bus.data_in;
                    state <= RUN;
                end
                RUN: begin
                    if (div_is_zero) begin
                        // Saturated quotient flags the error; dividend stays in R.
                        dbz_q  <= 1'b1;
                        quo_q  <= '1;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end else if (rem_ge_div) begin
                        rem_q <= rem_minus_div;
                        quo_q <= quo_q + 1'b1;
                    end else begin
                        done_q <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.quotient    = quo_q;
    assign bus.remainder   = rem_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: 16-bit and 8-bit instances share one stimulus driver.
// Latency: expected results are queued when an operation is issued and compared when done rises.
// Backpressure: exercises start pulses while busy and an asynchronous abort mid-operation.
module tb_seq_divider;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seq_divider_if #(.WIDTH(16)) b16 ();
    seq_divider_if #(.WIDTH(8))  b8 ();

    seq_divider #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(b16.slave));
    seq_divider #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(b8.slave));

    // sel picks which instance receives stimulus and is observed.
    logic        sel = 1'b0;
    logic        start_r = 1'b0;
    logic [15:0] din = '0;

    assign b16.start   = start_r & ~sel;
    assign b16.data_in = din;
    assign b8.start    = start_r & sel;
    assign b8.data_in  = din[7:0];

    logic        obs_busy, obs_done, obs_dbz;
    logic [15:0] obs_q, obs_r;
    assign obs_busy = sel ? b8.busy        : b16.busy;
    assign obs_done = sel ? b8.done        : b16.done;
    assign obs_dbz  = sel ? b8.div_by_zero : b16.div_by_zero;
    assign obs_q    = sel ? {8'h00, b8.quotient}  : b16.quotient;
    assign obs_r    = sel ? {8'h00, b8.remainder} : b16.remainder;

    typedef struct {
        logic [15:0] q;
        logic [15:0] r;
        logic        dbz;
        int          done_edge;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one operation on the selected instance and check it through done.
    // poke >= 2 pulses start (with junk data) after that edge, while RUN is active.
    task automatic run_op(input string tag, input logic s, input logic [15:0] n,
                          input logic [15:0] dv, input int poke);
        exp_t        e;
        logic [15:0] mask;
        int          edge_idx;
        logic        busy_ok;
        mask = s ? 16'h00FF : 16'hFFFF;
        if (dv == 16'd0) begin
            e.q = mask;
            e.r = n;
            e.dbz = 1'b1;
            e.done_edge = 2;
        end else begin
            e.q = n / dv;
            e.r = n % dv;
            e.dbz = 1'b0;
            e.done_edge = int'(n / dv) + 2;
        end
        sb.push_back(e);

        @(negedge clk);
        sel = s;
        start_r = 1'b1;
        din = n;
        @(posedge clk);
        #1;
        edge_idx = 0;
        check({tag, "_busy_after_start"}, {31'd0, obs_busy}, 32'd1);
        start_r = 1'b0;
        din = dv;
        busy_ok = 1'b1;
        while (obs_done !== 1'b1 && edge_idx < 400) begin
            if (obs_busy !== 1'b1) busy_ok = 1'b0;
            start_r = (edge_idx == poke);
            if (edge_idx == poke) din = 16'h0003;
            @(posedge clk);
            #1;
            edge_idx++;
        end
        start_r = 1'b0;
        e = sb.pop_front();
        check({tag, "_done_edge"}, edge_idx, e.done_edge);
        check({tag, "_busy_held"}, {31'd0, busy_ok & obs_busy}, 32'd1);
        check({tag, "_quotient"}, {16'd0, obs_q}, {16'd0, e.q});
        check({tag, "_remainder"}, {16'd0, obs_r}, {16'd0, e.r});
        check({tag, "_div_by_zero"}, {31'd0, obs_dbz}, {31'd0, e.dbz});
        @(posedge clk);
        #1;
        check({tag, "_done_single"}, {30'd0, obs_done, obs_busy}, 32'd0);
        check({tag, "_q_hold"}, {16'd0, obs_q}, {16'd0, e.q});
    endtask

    initial begin
        // Reset state.
        #1;
        check("rst_q", {16'd0, b16.quotient}, 32'd0);
        check("rst_r", {16'd0, b16.remainder}, 32'd0);
        check("rst_flags", {29'd0, b16.busy, b16.done, b16.div_by_zero}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("div100_7", 1'b0, 16'd100, 16'd7, -1);
        run_op("div5_9", 1'b0, 16'd5, 16'd9, -1);
        run_op("div48_6", 1'b0, 16'd48, 16'd6, -1);
        run_op("div42_0", 1'b0, 16'd42, 16'd0, -1);
        run_op("div9_3", 1'b0, 16'd9, 16'd3, -1);
        run_op("div0_5", 1'b0, 16'd0, 16'd5, -1);
        run_op("w8_255_1", 1'b1, 16'd255, 16'd1, -1);
        run_op("start_mid_run", 1'b0, 16'd100, 16'd7, 5);

        // Asynchronous abort in the middle of RUN.
        @(negedge clk);
        sel = 1'b0;
        start_r = 1'b1;
        din = 16'd1000;
        @(posedge clk);
        #1;
        start_r = 1'b0;
        din = 16'd3;
        repeat (5) @(posedge clk);
        #3;
        check("abort_busy_before", {31'd0, b16.busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_q", {16'd0, b16.quotient}, 32'd0);
        check("abort_r", {16'd0, b16.remainder}, 32'd0);
        check("abort_flags", {29'd0, b16.busy, b16.done, b16.div_by_zero}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("abort_no_done", {30'd0, b16.busy, b16.done}, 32'd0);

        run_op("div20_4", 1'b0, 16'd20, 16'd4, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
